// File: rtl/mem_access.sv
// mem_access: memory-access stage between ex_mem and mem_wb; runs byte/half/word
//   loads and stores over a req/ack bus and formats load data for writeback.
// Latency: non-memory ops pass through combinationally; an aligned memory op takes
//   IDLE->REQ(n cycles)->DONE, so at least 3 cycles with an ack in the first REQ cycle.
// Backpressure: stall_req holds ex_mem and earlier stages while an access is in
//   flight; a missing ack is aborted after ACK_TIMEOUT REQ cycles and flagged on bus_err.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ex_*                instruction fields from the ex_mem register
//   mem_*               fields toward mem_wb
//   stall_req           upstream hold request
//   addr_err, bus_err   misaligned access flag (comb), bus timeout pulse
//   bus_*               registered req/ack data bus (big-endian byte lanes)
module mem_access #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_wReg,
    input  logic [4:0]  ex_wAddr,
    input  logic [31:0] ex_wData,
    input  logic        ex_wHiLo,
    input  logic [31:0] ex_hiData,
    input  logic [31:0] ex_loData,
    input  logic [3:0]  ex_memOp,
    input  logic [31:0] ex_memAddr,
    input  logic [31:0] ex_storeData,

    output logic        mem_wReg,
    output logic [4:0]  mem_wAddr,
    output logic [31:0] mem_wData,
    output logic        mem_wHiLo,
    output logic [31:0] mem_hiData,
    output logic [31:0] mem_loData,

    output logic        stall_req,
    output logic        addr_err,
    output logic        bus_err,

    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    // Memory op encodings on ex_memOp; anything else is a non-memory instruction.
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    // Counter wide enough to hold ACK_TIMEOUT-1 (at least one bit).
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic           bus_req_q;
    logic           bus_we_q;
    logic [31:0]    bus_addr_q;
    logic [3:0]     bus_sel_q;
    logic [31:0]    bus_wdata_q;
    logic [31:0]    rdata_q;
    logic [CW-1:0]  cnt_q;
    logic           err_q;

    // ------------------------------------------------------------------
    // Op decode
    // ------------------------------------------------------------------
    logic is_load, is_store, is_byte, is_half, is_word, is_mem;
    logic misaligned, op_go;

    always_comb begin
        is_load  = (ex_memOp == OP_LB) || (ex_memOp == OP_LBU) || (ex_memOp == OP_LH) ||
                   (ex_memOp == OP_LHU) || (ex_memOp == OP_LW);
        is_store = (ex_memOp == OP_SB) || (ex_memOp == OP_SH) || (ex_memOp == OP_SW);
        is_byte  = (ex_memOp == OP_LB) || (ex_memOp == OP_LBU) || (ex_memOp == OP_SB);
        is_half  = (ex_memOp == OP_LH) || (ex_memOp == OP_LHU) || (ex_memOp == OP_SH);
        is_word  = (ex_memOp == OP_LW) || (ex_memOp == OP_SW);
        is_mem   = is_load || is_store;
        misaligned = (is_half && ex_memAddr[0]) || (is_word && (ex_memAddr[1:0] != 2'b00));
        op_go      = is_mem && !misaligned;
    end

    // ------------------------------------------------------------------
    // Next bus-register values captured when an access is launched
    // ------------------------------------------------------------------
    logic [3:0]  bus_sel_d;
    logic [31:0] bus_wdata_d;
    logic [31:0] bus_addr_d;

    always_comb begin
        bus_addr_d = {ex_memAddr[31:2], 2'b00};
        bus_sel_d  = 4'b0000;
        if (is_byte) begin
            // Big-endian: byte 0 of the word lives in bits [31:24].
            case (ex_memAddr[1:0])
                2'b00:   bus_sel_d = 4'b1000;
                2'b01:   bus_sel_d = 4'b0100;
                2'b10:   bus_sel_d = 4'b0010;
                default: bus_sel_d = 4'b0001;
            endcase
        end else if (is_half) begin
            bus_sel_d = ex_memAddr[1] ? 4'b0011 : 4'b1100;
        end else if (is_word) begin
            bus_sel_d = 4'b1111;
        end

        // Replicate narrow store data across all lanes; bus_sel picks the live one.
        if (ex_memOp == OP_SB) begin
            bus_wdata_d = {4{ex_storeData[7:0]}};
        end else if (ex_memOp == OP_SH) begin
            bus_wdata_d = {2{ex_storeData[15:0]}};
        end else begin
            bus_wdata_d = ex_storeData;
        end
    end

    // ------------------------------------------------------------------
    // FSM and registered bus outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_sel_q   <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_go) begin
                        state_q     <= REQ;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= is_store;
                        bus_addr_q  <= bus_addr_d;
                        bus_sel_q   <= bus_sel_d;
                        bus_wdata_q <= bus_wdata_d;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        rdata_q   <= bus_rdata;
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_MAX) begin
                        // No ack within the budget: abandon the access and flag it.
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load data formatting from the captured read word
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        case (ex_memAddr[1:0])
            2'b00:   ld_byte = rdata_q[31:24];
            2'b01:   ld_byte = rdata_q[23:16];
            2'b10:   ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = ex_memAddr[1] ? rdata_q[15:0] : rdata_q[31:16];

        case (ex_memOp)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Writeback/stall outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_wReg   = ex_wReg;
        mem_wAddr  = ex_wAddr;
        mem_wData  = ex_wData;
        mem_wHiLo  = ex_wHiLo;
        mem_hiData = ex_hiData;
        mem_loData = ex_loData;
        stall_req  = 1'b0;
        bus_err    = 1'b0;

        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    mem_wReg = 1'b0;
                end else if (op_go) begin
                    // Bubble into mem_wb until the access completes.
                    stall_req = 1'b1;
                    mem_wReg  = 1'b0;
                    mem_wHiLo = 1'b0;
                end
            end
            REQ: begin
                stall_req = 1'b1;
                mem_wReg  = 1'b0;
                mem_wHiLo = 1'b0;
            end
            DONE: begin
                // ex_* still holds the stalled instruction here.
                if (is_load) begin
                    mem_wData = ld_data;
                end
                if (err_q) begin
                    mem_wReg = 1'b0;
                    bus_err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign addr_err  = misaligned;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage between the ex_mem pipeline register and mem_wb.
- Executes LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus and formats load data (byte-lane select, sign/zero extension).
- Raises stall_req while a bus transaction is outstanding.
- Non-memory instructions pass their writeback and HI/LO fields through to mem_wb combinationally.

Parameters:
- ACK_TIMEOUT, 16: maximum cycles in REQ waiting for bus_ack before aborting; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- ex_wReg  in  1  register write enable from ex_mem
- ex_wAddr  in  5  destination register
- ex_wData  in  32  ALU result for non-load instructions
- ex_wHiLo  in  1  HI/LO write enable
- ex_hiData  in  32  HI value
- ex_loData  in  32  LO value
- ex_memOp  in  4  memory op: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- ex_memAddr  in  32  effective byte address
- ex_storeData  in  32  rt value for stores
- mem_wReg  out  1  to mem_wb
- mem_wAddr  out  5  to mem_wb
- mem_wData  out  32  to mem_wb
- mem_wHiLo  out  1  to mem_wb
- mem_hiData  out  32  to mem_wb
- mem_loData  out  32  to mem_wb
- stall_req  out  1  hold ex_mem and earlier stages
- addr_err  out  1  misaligned-access flag (combinational)
- bus_err  out  1  timeout flag, one-cycle pulse
- bus_req  out  1  registered bus request
- bus_we  out  1  registered write strobe
- bus_addr  out  32  registered word address, bits [1:0] = 00
- bus_sel  out  4  registered byte enables, big-endian
- bus_wdata  out  32  registered store data
- bus_rdata  in  32  read data, valid when bus_ack=1
- bus_ack  in  1  transaction complete

Behaviour:
- Byte lanes are big-endian:
  - addr[1:0]=00 → sel 1000, data[31:24]
  - 01 → 0100, [23:16]
  - 10 → 0010, [15:8]
  - 11 → 0001, [7:0]
  - Halfword at addr[1]=0 → sel 1100, [31:16]; addr[1]=1 → 0011, [15:0].
  - Word → 1111.
- Store data replication: SB drives {4{rt[7:0]}}; SH drives {2{rt[15:0]}}; SW drives rt.
- Misaligned access: halfword op with addr[0]=1, or word op with addr[1:0]≠00.
  - addr_err=1 combinationally.
  - No bus access, no stall.
  - mem_wReg=0; mem_wHiLo passes through.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - memOp none, or op misaligned: mem_* = ex_* combinationally; stall_req=0.
  - Valid aligned op: stall_req=1; mem_wReg=0 and mem_wHiLo=0 (bubble into mem_wb).
  - On the clock edge with a valid aligned op: load bus_req=1, bus_we (1 for stores), bus_addr, bus_sel, bus_wdata; clear the timeout counter; go to REQ.
- REQ:
  - Bus outputs held stable; stall_req=1; mem_wReg=0; mem_wHiLo=0.
  - bus_ack=1: at that edge bus_req←0, bus_we←0, bus_rdata captured into rdata_q, go to DONE.
  - Otherwise the counter increments. When the counter reaches ACK_TIMEOUT-1 with no ack: bus_req←0, error flag set, go to DONE.
  - bus_ack sampled only in REQ; ack in any other state is ignored.
- DONE (exactly one cycle):
  - stall_req=0; ex_* still holds the same instruction because upstream was stalled.
  - Loads: mem_wReg=ex_wReg; mem_wData = formatted rdata_q.
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - Stores: mem_wReg=ex_wReg (normally 0).
  - HI/LO fields pass through.
  - If the timeout flag is set: bus_err=1 and mem_wReg=0.
  - Next state IDLE; the error flag clears.
- Back-to-back memory ops: DONE→IDLE→REQ. Each access costs at least 3 cycles with ack in the first REQ cycle.
- Reset (rst=0, any time, including mid-transaction):
  - State IDLE; bus_req, bus_we = 0; bus_addr, bus_sel, bus_wdata, rdata_q = 0; counter and error flag = 0.
  - Combinational outputs follow IDLE rules.
  - A pending ack arriving after reset release is ignored.

Test Plan:
- ALU op passthrough: memOp=0, ex_wReg=1, wAddr=5, wData=0x1234, wHiLo=1 → same cycle mem_* equal the inputs, stall_req=0, bus_req stays 0.
- LB at 0x1001, ack in first REQ cycle, rdata=0x11F23344 → bus_addr=0x1000, sel=0100. REQ cycle: stall=1, mem_wReg=0. DONE: mem_wData=0xFFFFFFF2, mem_wReg=1, stall_req=0.
- LHU at 0x2002, rdata=0xAAAA8001, ack after 3 wait cycles → sel=0011; stall held 4 cycles in REQ; DONE wData=0x00008001.
- SB rt=0x000000A5 at 0x3003 → bus_we=1, sel=0001, wdata=0xA5A5A5A5; bus_req falls after ack; DONE mem_wReg=0.
- LW at 0x4002 → addr_err=1, bus_req=0, stall_req=0, mem_wReg=0. Same for LH at 0x4001.
- LW with ACK_TIMEOUT=16, no ack → bus_req held 16 cycles then drops; DONE bus_err=1 pulse, mem_wReg=0. Second case: rst pulsed low during REQ → bus_req=0 asynchronously, state IDLE, later stray ack ignored.
